// File: rtl/id_pkg.sv
// Shared opcode encodings, instruction field positions and the control decode
// used by the instruction-decode stage.
package id_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int RD_MSB     = 15;
    localparam int RD_LSB     = 11;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;

    typedef enum logic [1:0] {DEST_NONE, DEST_RD, DEST_RT} dest_sel_e;
    typedef enum logic [1:0] {IMM_SIGN, IMM_ZERO, IMM_UPPER} imm_kind_e;

    typedef struct packed {
        logic      reg_write;
        logic      mem_read;
        logic      mem_write;
        logic      alu_src;
        logic      branch;
        dest_sel_e dest_sel;
    } ctrl_t;

    function automatic ctrl_t decode_ctrl(input logic [5:0] opcode);
        ctrl_t c;
        c = '{default: '0, dest_sel: DEST_NONE};
        case (opcode)
            OP_RTYPE: begin
                c.reg_write = 1'b1;
                c.dest_sel  = DEST_RD;
            end
            OP_LW: begin
                c.reg_write = 1'b1;
                c.mem_read  = 1'b1;
                c.alu_src   = 1'b1;
                c.dest_sel  = DEST_RT;
            end
            OP_SW: begin
                c.mem_write = 1'b1;
                c.alu_src   = 1'b1;
            end
            OP_BEQ, OP_BNE: c.branch = 1'b1;
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                c.reg_write = 1'b1;
                c.alu_src   = 1'b1;
                c.dest_sel  = DEST_RT;
            end
            default: c = '{default: '0, dest_sel: DEST_NONE};
        endcase
        return c;
    endfunction

    function automatic imm_kind_e imm_kind(input logic [5:0] opcode);
        case (opcode)
            OP_ANDI, OP_ORI, OP_XORI: return IMM_ZERO;
            OP_LUI:                   return IMM_UPPER;
            default:                  return IMM_SIGN;
        endcase
    endfunction

endpackage

// File: rtl/id_regfile_bypass.sv
// Register file with write-through bypass on both decode read ports and an
// unbypassed debug read of the stored contents.
module id_regfile_bypass
    import id_pkg::*;
#(
    parameter int NB_DATA = 32,
    parameter int NB_REG  = 5,
    parameter int N_REGS  = 32
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_wb_en,
    input  logic [NB_REG-1:0]  i_wb_addr,
    input  logic [NB_DATA-1:0] i_wb_data,
    input  logic [NB_REG-1:0]  i_rd_addr [2],
    output logic [NB_DATA-1:0] o_rd_data [2],
    input  logic [NB_REG-1:0]  i_dbg_addr,
    output logic [NB_DATA-1:0] o_dbg_data
);

    logic [NB_DATA-1:0] regs_reg [N_REGS];
    logic               wr_en;

    // Entry 0 is never written, so it stays at its reset value of zero.
    assign wr_en = i_wb_en && (i_wb_addr != '0) && (int'(i_wb_addr) < N_REGS);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < N_REGS; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (wr_en) begin
            regs_reg[i_wb_addr] <= i_wb_data;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd_port
            logic [NB_REG-1:0] addr;
            assign addr = i_rd_addr[gi];
            assign o_rd_data[gi] =
                ((addr == '0) || (int'(addr) >= N_REGS)) ? '0 :
                (i_wb_en && (i_wb_addr == addr))         ? i_wb_data :
                                                           regs_reg[addr];
        end
    endgenerate

    assign o_dbg_data = ((i_dbg_addr == '0) || (int'(i_dbg_addr) >= N_REGS)) ? '0
                                                                              : regs_reg[i_dbg_addr];

endmodule

// File: rtl/id_stage_pipe.sv
// Instruction decode stage: operand read, immediate/control decode, load-use
// hazard detection and the ID/EX pipeline register.
module id_stage_pipe
    import id_pkg::*;
#(
    parameter int NB_DATA = 32,
    parameter int NB_INST = 32,
    parameter int NB_ADDR = 32,
    parameter int NB_REG  = 5,
    parameter int N_REGS  = 32
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    input  logic [NB_ADDR-1:0] i_pc,
    input  logic [NB_INST-1:0] i_instruction,
    input  logic               i_wb_en,
    input  logic [NB_REG-1:0]  i_wb_addr,
    input  logic [NB_DATA-1:0] i_wb_data,
    input  logic               i_ex_mem_read,
    input  logic [NB_REG-1:0]  i_ex_rt,
    input  logic               i_flush,
    input  logic [NB_REG-1:0]  i_address_read_debug,
    output logic [NB_DATA-1:0] o_data_read_debug,
    output logic               o_stall,
    output logic               o_valid,
    output logic [NB_ADDR-1:0] o_pc,
    output logic [NB_DATA-1:0] o_data_1,
    output logic [NB_DATA-1:0] o_data_2,
    output logic [NB_DATA-1:0] o_imm,
    output logic [NB_REG-1:0]  o_rs,
    output logic [NB_REG-1:0]  o_rt,
    output logic [NB_REG-1:0]  o_dest,
    output logic [5:0]         o_funct,
    output logic [5:0]         o_opcode,
    output logic               o_reg_write,
    output logic               o_mem_read,
    output logic               o_mem_write,
    output logic               o_alu_src,
    output logic               o_branch,
    output logic [15:0]        o_stall_count
);

    logic [5:0]         opcode;
    logic [5:0]         funct;
    logic [NB_REG-1:0]  rs;
    logic [NB_REG-1:0]  rt;
    logic [NB_REG-1:0]  rd;
    logic [15:0]        imm16;
    logic [NB_REG-1:0]  rd_addr [2];
    logic [NB_DATA-1:0] rd_data [2];
    ctrl_t              ctrl;
    logic [NB_DATA-1:0] imm_ext;
    logic [NB_REG-1:0]  dest;
    logic               stall;
    logic               load_bubble;

    assign opcode = i_instruction[OPCODE_MSB:OPCODE_LSB];
    assign funct  = i_instruction[FUNCT_MSB:FUNCT_LSB];
    assign rs     = NB_REG'(i_instruction[RS_MSB:RS_LSB]);
    assign rt     = NB_REG'(i_instruction[RT_MSB:RT_LSB]);
    assign rd     = NB_REG'(i_instruction[RD_MSB:RD_LSB]);
    assign imm16  = i_instruction[IMM_MSB:IMM_LSB];

    assign rd_addr[0] = rs;
    assign rd_addr[1] = rt;

    id_regfile_bypass #(
        .NB_DATA (NB_DATA),
        .NB_REG  (NB_REG),
        .N_REGS  (N_REGS)
    ) u_regfile (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_wb_en    (i_wb_en),
        .i_wb_addr  (i_wb_addr),
        .i_wb_data  (i_wb_data),
        .i_rd_addr  (rd_addr),
        .o_rd_data  (rd_data),
        .i_dbg_addr (i_address_read_debug),
        .o_dbg_data (o_data_read_debug)
    );

    assign ctrl = decode_ctrl(opcode);

    always_comb begin
        imm_ext = NB_DATA'($signed(imm16));
        case (imm_kind(opcode))
            IMM_ZERO:  imm_ext = NB_DATA'(imm16);
            IMM_UPPER: imm_ext = NB_DATA'({imm16, 16'h0000});
            default:   imm_ext = NB_DATA'($signed(imm16));
        endcase
    end

    always_comb begin
        dest = '0;
        case (ctrl.dest_sel)
            DEST_RD: dest = rd;
            DEST_RT: dest = rt;
            default: dest = '0;
        endcase
    end

    // A flush squashes the instruction anyway, so it never needs to hold IF/ID.
    assign stall = i_valid && i_ex_mem_read && !i_flush && (i_ex_rt != '0) &&
                   ((i_ex_rt == rs) || (i_ex_rt == rt));
    assign o_stall     = stall;
    assign load_bubble = i_flush || stall || !i_valid;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid       <= 1'b0;
            o_pc          <= '0;
            o_data_1      <= '0;
            o_data_2      <= '0;
            o_imm         <= '0;
            o_rs          <= '0;
            o_rt          <= '0;
            o_dest        <= '0;
            o_funct       <= '0;
            o_opcode      <= '0;
            o_reg_write   <= 1'b0;
            o_mem_read    <= 1'b0;
            o_mem_write   <= 1'b0;
            o_alu_src     <= 1'b0;
            o_branch      <= 1'b0;
            o_stall_count <= '0;
        end else begin
            if (load_bubble) begin
                o_valid     <= 1'b0;
                o_pc        <= '0;
                o_data_1    <= '0;
                o_data_2    <= '0;
                o_imm       <= '0;
                o_rs        <= '0;
                o_rt        <= '0;
                o_dest      <= '0;
                o_funct     <= '0;
                o_opcode    <= '0;
                o_reg_write <= 1'b0;
                o_mem_read  <= 1'b0;
                o_mem_write <= 1'b0;
                o_alu_src   <= 1'b0;
                o_branch    <= 1'b0;
            end else begin
                o_valid     <= 1'b1;
                o_pc        <= i_pc;
                o_data_1    <= rd_data[0];
                o_data_2    <= rd_data[1];
                o_imm       <= imm_ext;
                o_rs        <= rs;
                o_rt        <= rt;
                o_dest      <= dest;
                o_funct     <= funct;
                o_opcode    <= opcode;
                o_reg_write <= ctrl.reg_write;
                o_mem_read  <= ctrl.mem_read;
                o_mem_write <= ctrl.mem_write;
                o_alu_src   <= ctrl.alu_src;
                o_branch    <= ctrl.branch;
            end
            if (stall && (o_stall_count != 16'hFFFF)) begin
                o_stall_count <= o_stall_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Randomized check of id_stage_pipe against a behavioural decode model, plus
// hand-computed directed cases.
module tb_id_stage_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        ex_mem_read;
    logic [4:0]  ex_rt;
    logic        flush;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic        stall;
    logic        o_valid;
    logic [31:0] o_pc, o_data_1, o_data_2, o_imm;
    logic [4:0]  o_rs, o_rt, o_dest;
    logic [5:0]  o_funct, o_opcode;
    logic        o_reg_write, o_mem_read, o_mem_write, o_alu_src, o_branch;
    logic [15:0] o_stall_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    id_stage_pipe dut (
        .i_clk                (clk),
        .i_rst_n              (rst_n),
        .i_valid              (valid),
        .i_pc                 (pc),
        .i_instruction        (instr),
        .i_wb_en              (wb_en),
        .i_wb_addr            (wb_addr),
        .i_wb_data            (wb_data),
        .i_ex_mem_read        (ex_mem_read),
        .i_ex_rt              (ex_rt),
        .i_flush              (flush),
        .i_address_read_debug (dbg_addr),
        .o_data_read_debug    (dbg_data),
        .o_stall              (stall),
        .o_valid              (o_valid),
        .o_pc                 (o_pc),
        .o_data_1             (o_data_1),
        .o_data_2             (o_data_2),
        .o_imm                (o_imm),
        .o_rs                 (o_rs),
        .o_rt                 (o_rt),
        .o_dest               (o_dest),
        .o_funct              (o_funct),
        .o_opcode             (o_opcode),
        .o_reg_write          (o_reg_write),
        .o_mem_read           (o_mem_read),
        .o_mem_write          (o_mem_write),
        .o_alu_src            (o_alu_src),
        .o_branch             (o_branch),
        .o_stall_count        (o_stall_count)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] mrf [32];
    logic [31:0] e_pc, e_d1, e_d2, e_imm;
    logic [4:0]  e_rs, e_rt, e_dest;
    logic [5:0]  e_funct, e_opcode;
    logic        e_valid, e_rw, e_mr, e_mw, e_as, e_br;
    int          e_cnt;

    function automatic bit hazard_now(input logic v, input logic [31:0] ins, input logic mr,
                                      input logic [4:0] ert, input logic fl);
        return v && mr && !fl && ert != 0 && (ert == ins[25:21] || ert == ins[20:16]);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) mrf[i] = 32'h0;
        {e_valid, e_rw, e_mr, e_mw, e_as, e_br} = '0;
        e_pc = 0; e_d1 = 0; e_d2 = 0; e_imm = 0;
        e_rs = 0; e_rt = 0; e_dest = 0; e_funct = 0; e_opcode = 0;
        e_cnt = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] idx, input logic we,
                                               input logic [4:0] wa, input logic [31:0] wd);
        if (idx == 0) return 32'h0;
        if (we && wa == idx) return wd;
        return mrf[idx];
    endfunction

    task automatic model_edge(input logic v, input logic [31:0] p, input logic [31:0] ins,
                              input logic we, input logic [4:0] wa, input logic [31:0] wd,
                              input logic mr, input logic [4:0] ert, input logic fl);
        int unsigned op, imm;
        bool_t: begin end
        op  = ins[31:26];
        imm = ins[15:0];
        if (fl || hazard_now(v, ins, mr, ert, fl) || !v) begin
            {e_valid, e_rw, e_mr, e_mw, e_as, e_br} = '0;
            e_pc = 0; e_d1 = 0; e_d2 = 0; e_imm = 0;
            e_rs = 0; e_rt = 0; e_dest = 0; e_funct = 0; e_opcode = 0;
        end else begin
            e_valid  = 1;
            e_pc     = p;
            e_rs     = ins[25:21];
            e_rt     = ins[20:16];
            e_funct  = ins[5:0];
            e_opcode = ins[31:26];
            e_d1     = model_read(ins[25:21], we, wa, wd);
            e_d2     = model_read(ins[20:16], we, wa, wd);
            if (op == 12 || op == 13 || op == 14) e_imm = imm;
            else if (op == 15)                    e_imm = imm << 16;
            else if (imm >= 32'h8000)             e_imm = imm | 32'hFFFF_0000;
            else                                  e_imm = imm;
            {e_rw, e_mr, e_mw, e_as, e_br} = '0;
            e_dest = 0;
            if (op == 0) begin
                e_rw = 1; e_dest = ins[15:11];
            end else if (op == 'h23) begin
                e_rw = 1; e_mr = 1; e_as = 1; e_dest = ins[20:16];
            end else if (op == 'h2B) begin
                e_mw = 1; e_as = 1;
            end else if (op >= 8 && op <= 15) begin
                e_rw = 1; e_as = 1; e_dest = ins[20:16];
            end else if (op == 4 || op == 5) begin
                e_br = 1;
            end
        end
        if (we && wa != 0) mrf[wa] = wd;
        if (hazard_now(v, ins, mr, ert, fl) && e_cnt < 65535) e_cnt++;
    endtask

    // Compare process: advance the model on each rising edge, check on the falling edge.
    initial begin
        model_clear();
        forever begin
            @(posedge clk);
            if (!rst_n) model_clear();
            else model_edge(valid, pc, instr, wb_en, wb_addr, wb_data, ex_mem_read, ex_rt, flush);
            @(negedge clk);
            if (!rst_n) model_clear();
            chk("stall",     stall,        hazard_now(valid, instr, ex_mem_read, ex_rt, flush));
            chk("valid",     o_valid,      e_valid);
            chk("pc",        o_pc,         e_pc);
            chk("data_1",    o_data_1,     e_d1);
            chk("data_2",    o_data_2,     e_d2);
            chk("imm",       o_imm,        e_imm);
            chk("rs",        o_rs,         e_rs);
            chk("rt",        o_rt,         e_rt);
            chk("dest",      o_dest,       e_dest);
            chk("funct",     o_funct,      e_funct);
            chk("opcode",    o_opcode,     e_opcode);
            chk("ctrl",      {o_reg_write, o_mem_read, o_mem_write, o_alu_src, o_branch},
                             {e_rw, e_mr, e_mw, e_as, e_br});
            chk("stall_cnt", o_stall_count, e_cnt[15:0]);
            chk("debug",     dbg_data,     mrf[dbg_addr]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic quiet();
        valid = 0; pc = 0; instr = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
        ex_mem_read = 0; ex_rt = 0; flush = 0; dbg_addr = 0;
    endtask

    task automatic drive_random();
        logic [5:0] ops [15];
        ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A,
                6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h02, 6'h3F};
        instr        = $urandom;
        instr[31:26] = ops[$urandom_range(0, 14)];
        instr[25:21] = 5'($urandom_range(0, 7));
        instr[20:16] = 5'($urandom_range(0, 7));
        valid        = ($urandom_range(0, 9) < 8);
        pc           = $urandom;
        wb_en        = $urandom_range(0, 1);
        wb_addr      = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
        wb_data      = $urandom;
        ex_mem_read  = $urandom_range(0, 1);
        ex_rt        = 5'($urandom_range(0, 7));
        flush        = ($urandom_range(0, 9) == 0);
        dbg_addr     = 5'($urandom_range(0, 31));
    endtask

    initial begin
        quiet();
        rst_n = 0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset valid", o_valid, 0);
        chk("reset count", o_stall_count, 0);
        rst_n = 1;

        // write r5, then add r3,r5,r0
        wb_en = 1; wb_addr = 5; wb_data = 32'h1234_5678;
        step();
        wb_en = 0; valid = 1; pc = 32'h100; instr = 32'h00A0_1820;
        step();
        chk("add data_1", o_data_1, 32'h1234_5678);
        chk("add dest", o_dest, 3);
        chk("add reg_write", o_reg_write, 1);

        // same-cycle write-back bypass
        wb_en = 1; wb_addr = 7; wb_data = 32'hA5A5_A5A5; instr = 32'h00E0_0820;
        step();
        chk("bypass data_1", o_data_1, 32'hA5A5_A5A5);

        // load-use hazard
        wb_en = 0; ex_mem_read = 1; ex_rt = 4; instr = 32'h0004_2020;
        #1;
        chk("hazard stall", stall, 1);
        step();
        chk("hazard bubble", o_valid, 0);
        chk("hazard count", o_stall_count, 1);
        ex_rt = 0;
        #1;
        chk("rt0 no stall", stall, 0);
        step();

        // immediate forms
        ex_mem_read = 0; instr = 32'h2001_FFFF;
        step();
        chk("imm addi", o_imm, 32'hFFFF_FFFF);
        instr = 32'h3401_FFFF;
        step();
        chk("imm ori", o_imm, 32'h0000_FFFF);
        instr = 32'h3C01_FFFF;
        step();
        chk("imm lui", o_imm, 32'hFFFF_0000);

        // r0 is hardwired to zero
        valid = 0; wb_en = 1; wb_addr = 0; wb_data = 32'h0000_DEAD;
        step();
        wb_en = 0; dbg_addr = 0;
        #1;
        chk("debug r0", dbg_data, 0);
        dbg_addr = 5;
        #1;
        chk("debug r5", dbg_data, 32'h1234_5678);

        // flush beats stall
        valid = 1; instr = 32'h0004_2020; ex_mem_read = 1; ex_rt = 4; flush = 1;
        #1;
        chk("flush stall", stall, 0);
        step();
        chk("flush bubble", o_valid, 0);
        chk("flush count", o_stall_count, 1);
        quiet();
        step();

        for (int c = 0; c < 2000; c++) begin
            drive_random();
            step();
        end

        // asynchronous reset mid-stream
        rst_n = 0;
        #1;
        chk("arst valid", o_valid, 0);
        chk("arst data", {o_data_1, o_data_2}, 0);
        chk("arst pc", o_pc, 0);
        chk("arst ctrl", {o_reg_write, o_mem_read, o_mem_write, o_alu_src, o_branch}, 0);
        chk("arst count", o_stall_count, 0);
        quiet();
        for (int r = 1; r < 32; r++) begin
            dbg_addr = 5'(r);
            #1;
            chk("arst regfile", dbg_data, 0);
        end
        @(posedge clk);
        #2;
        rst_n = 1;

        for (int c = 0; c < 200; c++) begin
            drive_random();
            step();
        end
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/id_stage_pipe.md
ID_STAGE_PIPE -- requirements
Module: id_stage_pipe

Interface
REQ-001 Parameter NB_DATA, default 32, register/data width.
REQ-002 Parameter NB_INST, default 32, instruction width; NB_ADDR, default 32, PC width.
REQ-003 Parameter NB_REG, default 5, register index width; N_REGS, default 32 (<= 2**NB_REG), register count.
REQ-004 Ports, in this order: i_clk  in  1  single clock, all state on rising edge.
REQ-005 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-006 i_valid  in  1  IF/ID instruction valid; i_pc  in  NB_ADDR; i_instruction  in  NB_INST.
REQ-007 i_wb_en  in  1; i_wb_addr  in  NB_REG; i_wb_data  in  NB_DATA  write-back port.
REQ-008 i_ex_mem_read  in  1; i_ex_rt  in  NB_REG  load in EX and its destination.
REQ-009 i_flush  in  1  squash instruction currently in decode.
REQ-010 i_address_read_debug  in  NB_REG; o_data_read_debug  out  NB_DATA  combinational debug read.
REQ-011 o_stall  out  1  combinational, freeze PC and IF/ID.
REQ-012 Registered ID/EX outputs: o_valid 1; o_pc NB_ADDR; o_data_1, o_data_2 NB_DATA; o_imm NB_DATA; o_rs, o_rt, o_dest NB_REG; o_funct 6; o_opcode 6.
REQ-013 Registered control outputs, 1 bit each: o_reg_write, o_mem_read, o_mem_write, o_alu_src, o_branch.
REQ-014 o_stall_count  out  16  saturating count of stall cycles.

Function
REQ-015 Fields: opcode [31:26], rs [25:21], rt [20:16], rd [15:11], funct [5:0], imm [15:0].
REQ-016 Register file: N_REGS x NB_DATA; write on rising edge when i_wb_en=1 and i_wb_addr!=0; index 0 reads 0 always.
REQ-017 Read bypass: if i_wb_en=1, i_wb_addr!=0 and i_wb_addr equals rs (rt), read data for rs (rt) is i_wb_data in the same cycle.
REQ-018 Indices >= N_REGS: writes ignored, reads return 0.
REQ-019 Immediate: opcodes 0x0C/0x0D/0x0E zero-extend; 0x0F yields {imm,16'b0}; all others sign-extend to NB_DATA.
REQ-020 Decode: 0x00 -> reg_write, dest=rd; 0x23 -> reg_write, mem_read, alu_src, dest=rt; 0x2B -> mem_write, alu_src; 0x08-0x0F -> reg_write, alu_src, dest=rt; 0x04/0x05 -> branch; other opcodes -> all control 0, dest=0.
REQ-021 Load-use hazard: o_stall=1 when i_valid=1, i_ex_mem_read=1, i_ex_rt!=0 and i_ex_rt equals rs or rt; otherwise 0.
REQ-022 Latency: one cycle; decoded instruction present on ID/EX outputs on the edge after i_valid=1 with no stall/flush.
REQ-023 Bubble: on an edge with i_flush=1, o_stall=1 or i_valid=0, o_valid and all control outputs load 0; data outputs hold don't-care-free zero.
REQ-024 i_flush has priority over stall; o_stall is forced 0 while i_flush=1.
REQ-025 Simultaneous write-back and decode of the same register resolves via REQ-017, never to stale data.
REQ-026 o_stall_count increments on each edge with o_stall=1, saturating at 0xFFFF.

Reset
REQ-027 While i_rst_n=0: all registered outputs 0, o_stall_count 0, every register file entry 0, asynchronously.
REQ-028 First decode occurs on the first rising edge after i_rst_n deasserts; a reset mid-stall drops the stalled instruction.

Structure
REQ-029 Package id_pkg holds opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI..OP_LUI) and field bit-position constants.
REQ-030 Sub-module id_regfile_bypass implements REQ-016..018 and the debug read; hazard, decode and ID/EX register live in the top.

Verification
REQ-031 Write 0x12345678 to r5, then decode add r3,r5,r0 -> next cycle o_data_1=0x12345678, o_dest=3, o_reg_write=1.
REQ-032 Same-cycle i_wb_en r7=0xA5A5A5A5 with decode of rs=7 -> o_data_1=0xA5A5A5A5.
REQ-033 i_ex_mem_read=1, i_ex_rt=4, decode rt=4 -> o_stall=1, next o_valid=0, o_stall_count=1; with i_ex_rt=0 -> o_stall=0.
REQ-034 imm 0xFFFF: opcode 0x08 -> o_imm=0xFFFFFFFF; 0x0D -> 0x0000FFFF; 0x0F -> 0xFFFF0000.
REQ-035 Write 0xDEAD to r0 -> debug read r0=0; i_flush=1 with hazard -> o_stall=0, o_valid=0.
REQ-036 Assert i_rst_n=0 asynchronously mid-stream -> outputs, counter and r1..r31 read 0 immediately.
